// File: rtl/fetch_align_if.sv
// Instruction memory bus between fetch_align and the instruction memory.
// The master side issues requests; the slave side acknowledges with data.
interface fetch_align_if #(
   parameter int XLEN = 32
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_align.sv
// Fetch aligner: turns word reads into 16/32-bit instructions at any
// halfword PC, reusing the upper halfword of the last word read.
module fetch_align #(
   parameter int XLEN = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [XLEN-1:0]    pc,
   input  logic               je,
   input  logic               id_ready,
   fetch_align_if.master      imem,
   output logic [31:0]        instr,
   output logic               instr_valid,
   output logic               compressed,
   output logic               stall
);

   localparam logic [1:0] FETCH    = 2'd0;
   localparam logic [1:0] FETCH_HI = 2'd1;
   localparam logic [1:0] VALID    = 2'd2;
   localparam logic [1:0] DRAIN    = 2'd3;

   localparam logic [XLEN-1:0] HALF = XLEN'(2);
   localparam logic [XLEN-1:0] WORD = XLEN'(4);

   logic [1:0]      state;
   logic [15:0]     lo_half;
   logic [15:0]     hold_data;
   logic [XLEN-1:0] hold_addr;
   logic            hold_valid;
   logic [XLEN-1:0] addr_q;
   logic            started;

   logic [XLEN-1:0] pc_h;
   logic [XLEN-1:0] pc_w;
   logic [XLEN-1:0] pc_w_next;
   logic            hit;
   logic            hit_c;
   logic            hit_w;
   logic            req_c;
   logic [XLEN-1:0] addr_c;
   logic            ack;
   logic            st_fetch;
   logic            st_hi;
   logic            st_valid;
   logic            st_drain;
   logic [31:0]     rdata;

   assign rdata     = imem.imem_rdata;
   assign pc_h      = pc & ~XLEN'(1);
   assign pc_w      = pc & ~XLEN'(3);
   assign pc_w_next = pc_w + WORD;

   // hold_addr is always a halfword address, so bit 0 compares as zero
   assign hit   = hold_valid && (pc_h == hold_addr);
   assign hit_c = hit && (hold_data[1:0] != 2'b11);
   assign hit_w = hit && (hold_data[1:0] == 2'b11);

   assign st_fetch = (state == FETCH);
   assign st_hi    = (state == FETCH_HI);
   assign st_valid = (state == VALID);
   assign st_drain = (state == DRAIN);

   always_comb begin
      req_c  = 1'b0;
      addr_c = pc_w;
      unique case (1'b1)
         st_fetch: begin
            if (hit_w) begin
               req_c  = 1'b1;
               addr_c = pc_w_next;
            end else if (!hit_c) begin
               req_c  = 1'b1;
               addr_c = pc_w;
            end
         end
         st_hi: begin
            req_c  = 1'b1;
            addr_c = pc_w_next;
         end
         st_drain: begin
            req_c  = 1'b1;
            addr_c = addr_q;
         end
         st_valid: begin
            req_c = 1'b0;
         end
         default: begin
            req_c = 1'b0;
         end
      endcase
   end

   // No request until the first edge after reset release
   assign imem.imem_req  = started && req_c;
   assign imem.imem_addr = addr_c;

   assign ack         = imem.imem_req && imem.imem_ack;
   assign instr_valid = st_valid;
   assign stall       = !(instr_valid && id_ready) && !je;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= FETCH;
         instr      <= 32'h0;
         compressed <= 1'b0;
         lo_half    <= 16'h0;
         hold_data  <= 16'h0;
         hold_addr  <= '0;
         hold_valid <= 1'b0;
         addr_q     <= '0;
         started    <= 1'b0;
      end else begin
         started <= 1'b1;
         if (imem.imem_req) begin
            addr_q <= imem.imem_addr;
         end
         if (ack && !je && (st_fetch || st_hi)) begin
            hold_data  <= rdata[31:16];
            hold_addr  <= imem.imem_addr + HALF;
            hold_valid <= 1'b1;
         end
         if (je) begin
            hold_valid <= 1'b0;
            if (imem.imem_req && !imem.imem_ack) begin
               state <= DRAIN;
            end else begin
               state <= FETCH;
            end
         end else begin
            unique case (1'b1)
               st_fetch: begin
                  if (!started) begin
                     state <= FETCH;
                  end else if (hit_c) begin
                     instr      <= {16'h0, hold_data};
                     compressed <= 1'b1;
                     state      <= VALID;
                  end else if (hit_w) begin
                     lo_half <= hold_data;
                     if (ack) begin
                        instr      <= {rdata[15:0], hold_data};
                        compressed <= 1'b0;
                        state      <= VALID;
                     end else begin
                        state <= FETCH_HI;
                     end
                  end else if (ack) begin
                     if (!pc[1]) begin
                        if (rdata[1:0] == 2'b11) begin
                           instr      <= rdata;
                           compressed <= 1'b0;
                        end else begin
                           instr      <= {16'h0, rdata[15:0]};
                           compressed <= 1'b1;
                        end
                        state <= VALID;
                     end else if (rdata[17:16] != 2'b11) begin
                        instr      <= {16'h0, rdata[31:16]};
                        compressed <= 1'b1;
                        state      <= VALID;
                     end else begin
                        lo_half <= rdata[31:16];
                        state   <= FETCH_HI;
                     end
                  end
               end
               st_hi: begin
                  if (ack) begin
                     instr      <= {rdata[15:0], lo_half};
                     compressed <= 1'b0;
                     state      <= VALID;
                  end
               end
               st_valid: begin
                  if (id_ready) begin
                     state <= FETCH;
                  end
               end
               st_drain: begin
                  if (ack) begin
                     state <= FETCH;
                  end
               end
               default: begin
                  state <= FETCH;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_align.sv
// Directed bench for fetch_align: lockstep stimulus with a hand-driven
// memory, expected values written out per scenario.
module tb_fetch_align;

   logic        clk;
   logic        reset_n;
   logic [31:0] pc;
   logic        je;
   logic        id_ready;
   logic [31:0] instr;
   logic        instr_valid;
   logic        compressed;
   logic        stall;

   int errors;
   int checks;

   fetch_align_if #(.XLEN(32)) bus ();

   fetch_align #(.XLEN(32)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .pc          (pc),
      .je          (je),
      .id_ready    (id_ready),
      .imem        (bus.master),
      .instr       (instr),
      .instr_valid (instr_valid),
      .compressed  (compressed),
      .stall       (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [31:0] p);
      reset_n        = 1'b0;
      je             = 1'b0;
      id_ready       = 1'b0;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'h0;
      pc             = p;
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic ack_with(input logic [31:0] d);
      bus.imem_rdata = d;
      bus.imem_ack   = 1'b1;
      tick();
      bus.imem_ack = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset_n        = 1'b0;
      je             = 1'b0;
      id_ready       = 1'b0;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'h0;
      pc             = 32'h0;
      tick();
      checks++;
      if (bus.imem_req !== 1'b0) begin
         errors++;
         $display("FAIL rst_req: got %b want 0", bus.imem_req);
      end
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL rst_stall: got %b want 1", stall);
      end
      checks++;
      if ({instr_valid, compressed, instr} !== 34'h0) begin
         errors++;
         $display("FAIL rst_out: got v=%b c=%b i=%h want 0", instr_valid, compressed, instr);
      end
      reset_n = 1'b1;
      #1;
      checks++;
      if (bus.imem_req !== 1'b0) begin
         errors++;
         $display("FAIL rst_first_req: got %b want 0", bus.imem_req);
      end
      tick();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL rst_req_after: got %b/%h want 1/00000000", bus.imem_req, bus.imem_addr);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.imem_req !== 1'b0 || stall !== 1'b1) begin
         errors++;
         $display("FAIL rst_async: got req=%b stall=%b want 0/1", bus.imem_req, stall);
      end
   endtask

   task automatic test_word_aligned();
      do_reset(32'h0);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL wa_req: got %b/%h want 1/00000000", bus.imem_req, bus.imem_addr);
      end
      ack_with(32'h00A00093);
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h00A00093 || compressed !== 1'b0) begin
         errors++;
         $display("FAIL wa_instr: got v=%b i=%h c=%b want 1/00a00093/0", instr_valid, instr, compressed);
      end
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL wa_stall_hold: got %b want 1", stall);
      end
      id_ready = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL wa_stall_rdy: got %b want 0", stall);
      end
      tick();
      pc       = 32'h4;
      id_ready = 1'b0;
      #1;
      checks++;
      if (instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin
         errors++;
         $display("FAIL wa_next: got v=%b req=%b a=%h want 0/1/00000004", instr_valid, bus.imem_req, bus.imem_addr);
      end
   endtask

   task automatic test_compressed_hold();
      do_reset(32'h0);
      ack_with(32'h00134505);
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h00004505 || compressed !== 1'b1) begin
         errors++;
         $display("FAIL ch_c16: got v=%b i=%h c=%b want 1/00004505/1", instr_valid, instr, compressed);
      end
      id_ready = 1'b1;
      tick();
      pc       = 32'h2;
      id_ready = 1'b0;
      #1;
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin
         errors++;
         $display("FAIL ch_hit_req: got %b/%h want 1/00000004", bus.imem_req, bus.imem_addr);
      end
      tick();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL ch_hi_hold: got req=%b a=%h v=%b want 1/00000004/0", bus.imem_req, bus.imem_addr, instr_valid);
      end
      ack_with(32'hABCD0050);
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h00500013 || compressed !== 1'b0) begin
         errors++;
         $display("FAIL ch_hi_instr: got v=%b i=%h c=%b want 1/00500013/0", instr_valid, instr, compressed);
      end
      id_ready = 1'b1;
      tick();
      pc       = 32'h6;
      id_ready = 1'b0;
      #1;
      checks++;
      if (bus.imem_req !== 1'b0) begin
         errors++;
         $display("FAIL ch_hit16_req: got %b want 0", bus.imem_req);
      end
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h0000ABCD || compressed !== 1'b1) begin
         errors++;
         $display("FAIL ch_hit16: got v=%b i=%h c=%b want 1/0000abcd/1", instr_valid, instr, compressed);
      end
   endtask

   task automatic test_straddle();
      do_reset(32'h2);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL st_lo_req: got %b/%h want 1/00000000", bus.imem_req, bus.imem_addr);
      end
      ack_with(32'h00931111);
      checks++;
      if (instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin
         errors++;
         $display("FAIL st_hi_req: got v=%b req=%b a=%h want 0/1/00000004", instr_valid, bus.imem_req, bus.imem_addr);
      end
      ack_with(32'h555500A0);
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h00A00093 || compressed !== 1'b0) begin
         errors++;
         $display("FAIL st_instr: got v=%b i=%h c=%b want 1/00a00093/0", instr_valid, instr, compressed);
      end
      do_reset(32'h2);
      ack_with(32'h45050000);
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h00004505 || compressed !== 1'b1) begin
         errors++;
         $display("FAIL st_odd16: got v=%b i=%h c=%b want 1/00004505/1", instr_valid, instr, compressed);
      end
   endtask

   task automatic test_drain();
      do_reset(32'h0);
      je = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL dr_stall: got %b want 0", stall);
      end
      tick();
      je = 1'b0;
      pc = 32'h100;
      #1;
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL dr_hold1: got req=%b a=%h v=%b want 1/00000000/0", bus.imem_req, bus.imem_addr, instr_valid);
      end
      je = 1'b1;
      tick();
      je = 1'b0;
      #1;
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL dr_hold2: got req=%b a=%h v=%b want 1/00000000/0", bus.imem_req, bus.imem_addr, instr_valid);
      end
      ack_with(32'hDEADBEEF);
      checks++;
      if (instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
         errors++;
         $display("FAIL dr_refetch: got v=%b req=%b a=%h want 0/1/00000100", instr_valid, bus.imem_req, bus.imem_addr);
      end
      ack_with(32'h00A00093);
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h00A00093) begin
         errors++;
         $display("FAIL dr_instr: got v=%b i=%h want 1/00a00093", instr_valid, instr);
      end
   endtask

   task automatic test_stall_hold();
      do_reset(32'h0);
      ack_with(32'h00A00093);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (instr !== 32'h00A00093 || instr_valid !== 1'b1 || stall !== 1'b1 || bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL sh_cyc%0d: got i=%h v=%b s=%b req=%b want 00a00093/1/1/0", i, instr, instr_valid, stall, bus.imem_req);
         end
         tick();
      end
   endtask

   task automatic test_je_valid();
      do_reset(32'h0);
      ack_with(32'h00134505);
      id_ready = 1'b1;
      je       = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL jv_stall: got %b want 0", stall);
      end
      tick();
      je       = 1'b0;
      id_ready = 1'b0;
      pc       = 32'h2;
      #1;
      checks++;
      if (instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL jv_flush: got v=%b req=%b a=%h want 0/1/00000000", instr_valid, bus.imem_req, bus.imem_addr);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_word_aligned();
      test_compressed_hold();
      test_straddle();
      test_drain();
      test_stall_hold();
      test_je_valid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
